// File: rtl/channel_row_tracker.sv
// Per-frame channel layout (restoring divider) plus incremental row-to-channel tracking for the trace display.
// Optional macro CHANNEL_BORDER_EN drives is_border on the first row of each channel; otherwise it is tied to 0.
module channel_row_tracker #(
  parameter  int MAX_CHAN_COUNT = 10,
  parameter  int V_RES          = 480,
  parameter  int OFFSET         = 0,
  localparam int ROW_W          = $clog2(V_RES),
  localparam int CH_W           = $clog2(MAX_CHAN_COUNT + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [MAX_CHAN_COUNT-1:0] channel_enable,
  input  logic                      frame_start,
  input  logic                      line_start,
  input  logic [ROW_W-1:0]          pixel_row,
  output logic                      layout_valid,
  output logic                      is_channel,
  output logic [CH_W-1:0]           channel_number,
  output logic [ROW_W-1:0]          channel_height,
  output logic [ROW_W-1:0]          channel_offset,
  output logic [ROW_W-1:0]          row_in_channel,
  output logic                      is_border
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DIV   = 2'd1;
  localparam logic [1:0] S_READY = 2'd2;

  localparam logic [ROW_W-1:0] DIVIDEND = ROW_W'(V_RES - OFFSET);
  localparam logic [ROW_W-1:0] OFF_R    = ROW_W'(OFFSET);
  localparam logic [ROW_W:0]   OFF_X    = (ROW_W+1)'(OFFSET);

  logic [1:0]                state_q;
  logic [MAX_CHAN_COUNT-1:0] mask_q;
  logic [CH_W-1:0]           count_q;
  logic [ROW_W-1:0]          div_sh_q, quo_q, cnt_q;
  logic [CH_W-1:0]           rem_q;
  logic [CH_W-1:0]           vis_q, phys_q;
  logic [ROW_W-1:0]          row_cnt_q, cur_off_q;
  logic                      valid_q, is_ch_q;
  logic [CH_W-1:0]           ch_num_q;
  logic [ROW_W-1:0]          height_q, ch_off_q, rin_q;

  function automatic logic [CH_W-1:0] first_set(input logic [MAX_CHAN_COUNT-1:0] m);
    logic [CH_W-1:0] r;
    r = '0;
    for (int k = MAX_CHAN_COUNT - 1; k >= 0; k--)
      if (m[k]) r = CH_W'(k);
    return r;
  endfunction

  logic [CH_W-1:0]           pop_cnt;
  logic [MAX_CHAN_COUNT-1:0] above_mask;
  always_comb begin
    pop_cnt    = '0;
    above_mask = '0;
    for (int k = 0; k < MAX_CHAN_COUNT; k++) begin
      pop_cnt       = pop_cnt + CH_W'(channel_enable[k]);
      above_mask[k] = mask_q[k] && (CH_W'(k) > phys_q);
    end
  end

  logic [CH_W-1:0] nxt_phys;
  assign nxt_phys = first_set(above_mask);

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  logic [CH_W:0]    rem_sh, rem_nx;
  logic             q_bit;
  logic [ROW_W-1:0] quo_nx;
  assign rem_sh = {rem_q, div_sh_q[ROW_W-1]};
  assign q_bit  = rem_sh >= {1'b0, count_q};
  assign rem_nx = q_bit ? rem_sh - {1'b0, count_q} : rem_sh;
  assign quo_nx = {quo_q[ROW_W-2:0], q_bit};

  // pixel_row < OFFSET, written so it stays well-formed when OFFSET is 0
  logic hdr_row, in_chan, trk_go;
  assign hdr_row = ({1'b0, pixel_row} + (ROW_W+1)'(1)) <= OFF_X;
  assign in_chan = !hdr_row && (vis_q < count_q);
  assign trk_go  = !frame_start && (state_q == S_READY) && line_start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      mask_q    <= '0;
      count_q   <= '0;
      div_sh_q  <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      rem_q     <= '0;
      vis_q     <= '0;
      phys_q    <= '0;
      row_cnt_q <= '0;
      cur_off_q <= '0;
      valid_q   <= 1'b0;
      is_ch_q   <= 1'b0;
      ch_num_q  <= '0;
      height_q  <= '0;
      ch_off_q  <= '0;
      rin_q     <= '0;
    end else if (frame_start) begin
      mask_q    <= channel_enable;
      count_q   <= pop_cnt;
      valid_q   <= (pop_cnt == '0);
      is_ch_q   <= 1'b0;
      div_sh_q  <= DIVIDEND;
      quo_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= ROW_W'(ROW_W - 1);
      state_q   <= (pop_cnt == '0) ? S_READY : S_DIV;
      if (pop_cnt == '0) height_q <= '0;
      // Tracker reset here makes row 0 land on the first channel when there is no header.
      vis_q     <= '0;
      row_cnt_q <= '0;
      cur_off_q <= OFF_R;
      phys_q    <= first_set(channel_enable);
    end else begin
      case (state_q)
        S_DIV: begin
          div_sh_q <= {div_sh_q[ROW_W-2:0], 1'b0};
          rem_q    <= rem_nx[CH_W-1:0];
          quo_q    <= quo_nx;
          cnt_q    <= cnt_q - ROW_W'(1);
          if (cnt_q == '0) begin
            height_q <= quo_nx;
            valid_q  <= 1'b1;
            state_q  <= S_READY;
          end
        end
        S_READY: begin
          if (line_start) begin
            is_ch_q  <= in_chan;
            ch_num_q <= in_chan ? phys_q    : '0;
            ch_off_q <= in_chan ? cur_off_q : '0;
            rin_q    <= in_chan ? row_cnt_q : '0;
            if (hdr_row) begin
              vis_q     <= '0;
              row_cnt_q <= '0;
              cur_off_q <= OFF_R;
              phys_q    <= first_set(mask_q);
            end else if (in_chan) begin
              if (row_cnt_q + ROW_W'(1) == height_q) begin
                row_cnt_q <= '0;
                vis_q     <= vis_q + CH_W'(1);
                cur_off_q <= cur_off_q + height_q;
                phys_q    <= nxt_phys;
              end else begin
                row_cnt_q <= row_cnt_q + ROW_W'(1);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CHANNEL_BORDER_EN
  logic border_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            border_q <= 1'b0;
    else if (frame_start) border_q <= 1'b0;
    else if (trk_go)      border_q <= in_chan && (row_cnt_q == '0);
  end
  assign is_border = border_q;
`else
  logic unused_trk;
  assign unused_trk = trk_go;
  assign is_border  = 1'b0;
`endif

  assign layout_valid   = valid_q;
  assign is_channel     = is_ch_q;
  assign channel_number = ch_num_q;
  assign channel_height = height_q;
  assign channel_offset = ch_off_q;
  assign row_in_channel = rin_q;

endmodule

// File: tb/tb_channel_row_tracker.sv
// Directed bench: an OFFSET=0 tracker and an OFFSET=32 tracker fed from the same stimulus.
module tb_channel_row_tracker;
`ifdef CHANNEL_BORDER_EN
  localparam bit BRD = 1'b1;
`else
  localparam bit BRD = 1'b0;
`endif

  logic       clk = 1'b0, reset = 1'b1, frame_start = 1'b0, line_start = 1'b0;
  logic [9:0] channel_enable = '0;
  logic [8:0] pixel_row = '0;

  logic       a_valid, a_isch, a_brd, b_valid, b_isch, b_brd;
  logic [3:0] a_ch, b_ch;
  logic [8:0] a_h, a_off, a_rin, b_h, b_off, b_rin;

  int checks = 0, errors = 0;

  channel_row_tracker #(.MAX_CHAN_COUNT(10), .V_RES(480), .OFFSET(0)) dut (
    .clk(clk), .reset(reset), .channel_enable(channel_enable), .frame_start(frame_start),
    .line_start(line_start), .pixel_row(pixel_row), .layout_valid(a_valid), .is_channel(a_isch),
    .channel_number(a_ch), .channel_height(a_h), .channel_offset(a_off),
    .row_in_channel(a_rin), .is_border(a_brd));

  channel_row_tracker #(.MAX_CHAN_COUNT(10), .V_RES(480), .OFFSET(32)) dut32 (
    .clk(clk), .reset(reset), .channel_enable(channel_enable), .frame_start(frame_start),
    .line_start(line_start), .pixel_row(pixel_row), .layout_valid(b_valid), .is_channel(b_isch),
    .channel_number(b_ch), .channel_height(b_h), .channel_offset(b_off),
    .row_in_channel(b_rin), .is_border(b_brd));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic line(input int r);
    line_start = 1'b1;
    pixel_row  = 9'(r);
    tick();
    line_start = 1'b0;
  endtask

  task automatic frame(input logic [9:0] m);
    channel_enable = m;
    frame_start    = 1'b1;
    tick();
    frame_start    = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int start);
    int c;
    c = start;
    while (!a_valid && c < 40) begin
      tick();
      c++;
    end
    chk(tag, c, 9);
  endtask

  initial begin
    tick();
    chk("rst_valid", a_valid, 0);
    chk("rst_isch", a_isch, 0);
    chk("rst_height", a_h, 0);
    chk("rst_chnum", a_ch, 0);
    chk("rst_border", a_brd, 0);
    reset = 1'b0;
    tick();

    // two channels (0 and 2), 240 rows each
    frame(10'b0000000101);
    chk("fs_valid_low", a_valid, 0);
    wait_valid("div_latency", 0);
    chk("h_240", a_h, 240);
    chk("h32_224", b_h, 224);
    for (int r = 0; r < 480; r++) begin
      line(r);
      if (r == 0) begin
        chk("r0_isch", a_isch, 1);
        chk("r0_ch", a_ch, 0);
        chk("r0_off", a_off, 0);
        chk("r0_border", a_brd, BRD);
      end
      if (r == 1) chk("r1_border", a_brd, 0);
      if (r == 239) begin
        chk("r239_ch", a_ch, 0);
        chk("r239_rin", a_rin, 239);
      end
      if (r == 240) begin
        chk("r240_ch", a_ch, 2);
        chk("r240_off", a_off, 240);
        chk("r240_rin", a_rin, 0);
        chk("r240_border", a_brd, BRD);
        channel_enable = 10'b1111110000;
      end
      if (r == 241) begin
        chk("midmask_ch", a_ch, 2);
        chk("midmask_rin", a_rin, 1);
      end
      if (r == 479) chk("r479_rin", a_rin, 239);
    end

    // seven channels 3..9, 68 rows each, 4 leftover rows
    frame(10'b1111111000);
    wait_valid("div_latency7", 0);
    chk("h_68", a_h, 68);
    for (int r = 0; r < 480; r++) begin
      line(r);
      if (r == 0) chk("m7_r0_ch", a_ch, 3);
      if (r == 408) begin
        chk("m7_r408_ch", a_ch, 9);
        chk("m7_r408_off", a_off, 408);
        chk("m7_r408_rin", a_rin, 0);
      end
      if (r == 475) chk("m7_r475_rin", a_rin, 67);
      if (r >= 476) chk("m7_tail_isch", a_isch, 0);
      if (r == 476) begin
        chk("m7_tail_ch", a_ch, 0);
        chk("m7_tail_off", a_off, 0);
        chk("m7_tail_rin", a_rin, 0);
      end
    end

    // single channel; dut32 has a 32-row header
    frame(10'b0000000001);
    wait_valid("div_latency1", 0);
    chk("h_480", a_h, 480);
    chk("h32_448", b_h, 448);
    for (int r = 0; r < 480; r++) begin
      line(r);
      if (r == 0 || r == 31) chk("hdr_isch", b_isch, 0);
      if (r == 32) begin
        chk("o32_isch", b_isch, 1);
        chk("o32_ch", b_ch, 0);
        chk("o32_off", b_off, 32);
        chk("o32_rin", b_rin, 0);
      end
      if (r == 479) begin
        chk("o32_r479_rin", b_rin, 447);
        chk("o0_r479_rin", a_rin, 479);
      end
    end

    // empty mask
    frame(10'b0000000000);
    chk("m0_valid", a_valid, 1);
    chk("m0_height", a_h, 0);
    line(0);
    chk("m0_r0_isch", a_isch, 0);
    line(100);
    chk("m0_r100_isch", a_isch, 0);

    // second frame_start three cycles after the first restarts the divider
    frame(10'b0000000101);
    tick();
    tick();
    frame(10'b1111111000);
    line(0);
    chk("div_line_ignored", a_isch, 0);
    chk("div_valid_low", a_valid, 0);
    wait_valid("restart_latency", 1);
    chk("restart_h", a_h, 68);
    line(0);
    chk("restart_r0_isch", a_isch, 1);
    chk("restart_r0_ch", a_ch, 3);

    // reset in the middle of a division
    frame(10'b0000000101);
    chk("fs_clears_isch", a_isch, 0);
    tick();
    reset = 1'b1;
    #1;
    chk("arst_valid", a_valid, 0);
    chk("arst_height", a_h, 0);
    chk("arst_chnum", a_ch, 0);
    chk("arst_h32", b_h, 0);
    reset = 1'b0;
    tick();
    tick();
    line(0);
    chk("idle_valid", a_valid, 0);
    chk("idle_isch", a_isch, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
